// File: rtl/gate_id_pkg.sv
// Shared constants for the gate identifier: known truth tables, function
// codes, field widths and the sweep FSM state encoding.
package gate_id_pkg;

    localparam int unsigned VEC_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TT_W   = 8;
    localparam int unsigned CODE_W = 2;

    // Truth tables indexed by {a,b,c}
    localparam logic [TT_W-1:0] TT_XOR3  = 8'h96;
    localparam logic [TT_W-1:0] TT_NAND3 = 8'h7F;
    localparam logic [TT_W-1:0] TT_NOR3  = 8'h01;
    localparam logic [TT_W-1:0] TT_XNOR3 = 8'h69;

    localparam logic [CODE_W-1:0] CODE_XOR3  = 2'b00;
    localparam logic [CODE_W-1:0] CODE_NAND3 = 2'b01;
    localparam logic [CODE_W-1:0] CODE_NOR3  = 2'b10;
    localparam logic [CODE_W-1:0] CODE_XNOR3 = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SWEEP_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SWEEP = ST_SWEEP_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/tt_classifier_v.sv
// Combinational decoder from an 8-bit truth table to a 3-input gate code.
// Ports: tt (table in), code (function code), match (table is a known gate).
module tt_classifier_v
    import gate_id_pkg::*;
(
    input  logic [TT_W-1:0]   tt,
    output logic [CODE_W-1:0] code,
    output logic              match
);

    always_comb begin
        code  = CODE_XOR3;
        match = 1'b0;
        case (tt)
            TT_XOR3:  begin code = CODE_XOR3;  match = 1'b1; end
            TT_NAND3: begin code = CODE_NAND3; match = 1'b1; end
            TT_NOR3:  begin code = CODE_NOR3;  match = 1'b1; end
            TT_XNOR3: begin code = CODE_XNOR3; match = 1'b1; end
            default:  begin code = CODE_XOR3;  match = 1'b0; end
        endcase
    end

endmodule

// File: rtl/gate_identifier_v.sv
// Sweeps all eight {a,b,c} vectors into an external gate, captures its truth
// table and identifies the gate function.
// Ports: i_clk, i_rst (async high), i_start; o_a/o_b/o_c drive the gate,
// i_f is its output; o_busy, o_done (pulse), o_table, o_code, o_match.
module gate_identifier_v
    import gate_id_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_a,
    output logic              o_b,
    output logic              o_c,
    input  logic              i_f,
    output logic              o_busy,
    output logic              o_done,
    output logic [TT_W-1:0]   o_table,
    output logic [CODE_W-1:0] o_code,
    output logic              o_match
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_identifier_v: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(7);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               match_q, match_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [TT_W-1:0]    cls_tt;
    logic [CODE_W-1:0]  cls_code;
    logic               cls_match;

    // Only bit 7 is still outstanding when the sweep completes
    assign cls_tt = {i_f, tt_q[TT_W-2:0]};

    tt_classifier_v u_classifier (
        .tt    (cls_tt),
        .code  (cls_code),
        .match (cls_match)
    );

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            code_q  <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            code_q  <= code_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        code_d  = code_q;
        match_d = match_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    cnt_d   = RELOAD;
                    tt_d    = '0;
                    code_d  = '0;
                    match_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    tt_d[idx_q] = i_f;
                    if (idx_q != LAST_VEC) begin
                        idx_d = idx_q + VEC_W'(1);
                        cnt_d = RELOAD;
                    end else begin
                        // Return the gate inputs to 000 for IDLE
                        state_d = ST_DONE;
                        idx_d   = '0;
                        code_d  = cls_code;
                        match_d = cls_match;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_SWEEP);
        done_d = (state_d == ST_DONE);
    end

    assign o_a     = idx_q[2];
    assign o_b     = idx_q[1];
    assign o_c     = idx_q[0];
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_table = tt_q;
    assign o_code  = code_q;
    assign o_match = match_q;

endmodule

// File: tb/tb_gate_identifier_v.sv
// Self-checking bench for gate_identifier_v: two instances (settle 2 and 1)
// each driving a behavioural 3-input gate built from a truth table.
module tb_gate_identifier_v;

    localparam int unsigned S0 = 2;
    localparam int unsigned S1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [1:0] f, a, b, c, busy, done, match;
    logic [7:0] tbl [2];
    logic [1:0] code [2];
    logic [7:0] model_tt [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External gate under test: a plain lookup into the table the bench chose
    assign f[0] = model_tt[0][{a[0], b[0], c[0]}];
    assign f[1] = model_tt[1][{a[1], b[1], c[1]}];

    gate_identifier_v #(.SETTLE_CYCLES(S0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]),
        .o_a(a[0]), .o_b(b[0]), .o_c(c[0]), .i_f(f[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_table(tbl[0]),
        .o_code(code[0]), .o_match(match[0])
    );

    gate_identifier_v #(.SETTLE_CYCLES(S1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]),
        .o_a(a[1]), .o_b(b[1]), .o_c(c[1]), .i_f(f[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_table(tbl[1]),
        .o_code(code[1]), .o_match(match[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gate behaviour from its boolean definition
    function automatic bit gate_fn(input int fn, input bit ia, input bit ib, input bit ic);
        case (fn)
            0:       return ia ^ ib ^ ic;
            1:       return !(ia && ib && ic);
            2:       return !(ia || ib || ic);
            default: return !(ia ^ ib ^ ic);
        endcase
    endfunction

    function automatic logic [7:0] build_tt(input int fn);
        logic [7:0] t;
        logic [2:0] v;
        for (int k = 0; k < 8; k++) begin
            v    = 3'(k);
            t[k] = gate_fn(fn, v[2], v[1], v[0]);
        end
        return t;
    endfunction

    // Reference identification: which gate definition reproduces this table
    task automatic classify(input logic [7:0] t, output logic [1:0] ec, output logic em);
        ec = 2'b00;
        em = 1'b0;
        for (int fn = 0; fn < 4; fn++) begin
            if (build_tt(fn) == t) begin
                ec = 2'(fn);
                em = 1'b1;
            end
        end
    endtask

    task automatic check_idle_zero(input int sel, input string tag);
        check({tag, "_vec"},   32'({a[sel], b[sel], c[sel]}), 32'd0);
        check({tag, "_busy"},  32'(busy[sel]),  32'd0);
        check({tag, "_done"},  32'(done[sel]),  32'd0);
        check({tag, "_table"}, 32'(tbl[sel]),   32'd0);
        check({tag, "_code"},  32'(code[sel]),  32'd0);
        check({tag, "_match"}, 32'(match[sel]), 32'd0);
    endtask

    // Full sweep from IDLE; optional extra start pulse after edge poke_n
    task automatic run_sweep(input int sel, input logic [7:0] tt, input int poke_n);
        int unsigned s;
        logic [1:0]  ec;
        logic        em;
        s = (sel == 0) ? S0 : S1;
        model_tt[sel] = tt;
        classify(tt, ec, em);
        start[sel] = 1'b1;
        @(posedge clk); #1;
        start[sel] = 1'b0;
        for (int n = 0; n < int'(8 * s); n++) begin
            check("sweep_vec",  32'({a[sel], b[sel], c[sel]}), 32'(n / int'(s)));
            check("sweep_busy", 32'(busy[sel]), 32'd1);
            check("sweep_done", 32'(done[sel]), 32'd0);
            start[sel] = (n == poke_n);
            @(posedge clk); #1;
        end
        start[sel] = 1'b0;
        check("done_pulse", 32'(done[sel]),  32'd1);
        check("done_busy",  32'(busy[sel]),  32'd0);
        check("done_table", 32'(tbl[sel]),   32'(tt));
        check("done_code",  32'(code[sel]),  32'(ec));
        check("done_match", 32'(match[sel]), 32'(em));
        @(posedge clk); #1;
        check("post_done",  32'(done[sel]),  32'd0);
        check("post_busy",  32'(busy[sel]),  32'd0);
        check("hold_table", 32'(tbl[sel]),   32'(tt));
        check("hold_code",  32'(code[sel]),  32'(ec));
        check("hold_match", 32'(match[sel]), 32'(em));
    endtask

    initial begin
        int          hits [$];
        logic [7:0]  rt;

        rst         = 1'b1;
        start       = 2'b00;
        model_tt[0] = 8'h00;
        model_tt[1] = 8'h00;
        #3;
        check_idle_zero(0, "reset0");
        check_idle_zero(1, "reset1");
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        // Each known gate
        for (int fn = 0; fn < 4; fn++) run_sweep(0, build_tt(fn), -1);

        // Stuck outputs are not gates
        run_sweep(0, 8'hFF, -1);
        run_sweep(0, 8'h00, -1);

        // Random tables, half of them drawn from the known gates
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) rt = build_tt(int'($urandom_range(0, 3)));
            else            rt = 8'($urandom);
            run_sweep(0, rt, -1);
        end

        // Extra start while sweeping vector 3 is ignored
        run_sweep(0, build_tt(3), int'(3 * S0));

        // Async reset while vector 5 is applied
        model_tt[0] = build_tt(1);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int n = 0; n < int'(5 * S0); n++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_vec", 32'({a[0], b[0], c[0]}), 32'd5);
        check("pre_rst_table", 32'(tbl[0]), 32'h1F);
        #2 rst = 1'b1;
        #1;
        check_idle_zero(0, "midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        run_sweep(0, build_tt(1), -1);

        // Fast instance: single sweep, then back-to-back with start held
        run_sweep(1, build_tt(2), -1);
        start[1] = 1'b1;
        for (int cyc = 1; cyc <= 40 && hits.size() < 3; cyc++) begin
            @(posedge clk); #1;
            if (done[1]) begin
                hits.push_back(cyc);
                check("b2b_table", 32'(tbl[1]),  32'h01);
                check("b2b_code",  32'(code[1]), 32'd2);
            end
        end
        start[1] = 1'b0;
        check("b2b_count", 32'(hits.size()), 32'd3);
        if (hits.size() == 3) begin
            check("b2b_first", 32'(hits[0]), 32'd9);
            check("b2b_gap1",  32'(hits[1] - hits[0]), 32'd10);
            check("b2b_gap2",  32'(hits[2] - hits[1]), 32'd10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
